// File: rtl/mc_controller_if.sv
// Bus between the multicycle controller and its datapath.
// The controller uses the master modport; the datapath/memories use the slave modport.
interface mc_controller_if #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
);
    logic [5:0]         operator;
    logic [5:0]         func;
    logic               alu_zero;
    logic               imem_ready;
    logic               dmem_ready;
    logic               resume;
    logic               imem_req;
    logic               ir_we;
    logic               dmem_req;
    logic               dmem_we;
    logic [ALUOP_W-1:0] aluop;
    logic               ext_16;
    logic               ext_s;
    logic               ext_5;
    logic               regwrite;
    logic               jal;
    logic               pc_we;
    logic [1:0]         pc_src;
    logic               halted;
    logic               illegal;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  operator, func, alu_zero, imem_ready, dmem_ready, resume,
        output imem_req, ir_we, dmem_req, dmem_we, aluop, ext_16, ext_s, ext_5,
               regwrite, jal, pc_we, pc_src, halted, illegal, retired
    );

    modport slave (
        output operator, func, alu_zero, imem_ready, dmem_ready, resume,
        input  imem_req, ir_we, dmem_req, dmem_we, aluop, ext_16, ext_s, ext_5,
               regwrite, jal, pc_we, pc_src, halted, illegal, retired
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer,
// decode flags latched in DECODE, retired-instruction counter.
module mc_controller #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_controller_if.master  ctrl_if
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]         r_state;
    logic [ALUOP_W-1:0] r_aluop;
    logic               r_ext_16, r_ext_s, r_ext_5;
    logic               r_to_wb, r_lw, r_sw, r_jal, r_beq, r_bne, r_jr, r_sys;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_retired;

    logic [3:0]         w_aluop;
    logic               w_ext_16, w_ext_s, w_ext_5;
    logic               w_to_wb, w_lw, w_sw, w_jal, w_beq, w_bne, w_jr, w_sys;
    logic               w_illegal;
    logic [2:0]         w_next;
    logic               w_pc_we;
    logic [1:0]         w_pc_src;
    logic               w_imem_req;

    // Instruction decode, only captured while in DECODE
    always_comb begin
        w_aluop   = 4'h0;
        w_ext_16  = 1'b0;
        w_ext_s   = 1'b0;
        w_ext_5   = 1'b0;
        w_to_wb   = 1'b0;
        w_lw      = 1'b0;
        w_sw      = 1'b0;
        w_jal     = 1'b0;
        w_beq     = 1'b0;
        w_bne     = 1'b0;
        w_jr      = 1'b0;
        w_sys     = 1'b0;
        w_illegal = 1'b0;
        case (ctrl_if.operator)
            6'h00: begin
                case (ctrl_if.func)
                    6'h00: begin w_aluop = 4'h0; w_ext_5 = 1'b1; w_to_wb = 1'b1; end
                    6'h02: begin w_aluop = 4'h2; w_ext_5 = 1'b1; w_to_wb = 1'b1; end
                    6'h03: begin w_aluop = 4'h1; w_ext_5 = 1'b1; w_to_wb = 1'b1; end
                    6'h08: w_jr  = 1'b1;
                    6'h0C: w_sys = 1'b1;
                    6'h20, 6'h21: begin w_aluop = 4'h5; w_to_wb = 1'b1; end
                    6'h22: begin w_aluop = 4'h6; w_to_wb = 1'b1; end
                    6'h24: begin w_aluop = 4'h7; w_to_wb = 1'b1; end
                    6'h25: begin w_aluop = 4'h8; w_to_wb = 1'b1; end
                    6'h27: begin w_aluop = 4'hA; w_to_wb = 1'b1; end
                    6'h2A: begin w_aluop = 4'hB; w_to_wb = 1'b1; end
                    6'h2B: begin w_aluop = 4'hC; w_to_wb = 1'b1; end
                    default: w_illegal = 1'b1;
                endcase
            end
            6'h03: w_jal = 1'b1;
            6'h04: begin w_aluop = 4'h6; w_ext_s = 1'b1; w_beq = 1'b1; end
            6'h05: begin w_aluop = 4'h6; w_ext_s = 1'b1; w_bne = 1'b1; end
            6'h08, 6'h09: begin w_aluop = 4'h5; w_ext_s = 1'b1; w_to_wb = 1'b1; end
            6'h0A: begin w_aluop = 4'hB; w_ext_s = 1'b1; w_to_wb = 1'b1; end
            6'h0C: begin w_aluop = 4'h7; w_ext_16 = 1'b1; w_to_wb = 1'b1; end
            6'h0D: begin w_aluop = 4'h8; w_ext_16 = 1'b1; w_to_wb = 1'b1; end
            6'h23: begin w_aluop = 4'h5; w_ext_s = 1'b1; w_lw = 1'b1; end
            6'h2B: begin w_aluop = 4'h5; w_ext_s = 1'b1; w_sw = 1'b1; end
            default: w_illegal = 1'b1;
        endcase
    end

    // Sequencing; the retire cycle is whichever state finishes the instruction
    always_comb begin
        w_next   = r_state;
        w_pc_we  = 1'b0;
        w_pc_src = 2'd0;
        case (r_state)
            S_FETCH:  if (ctrl_if.imem_ready) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (r_to_wb || r_jal) begin
                    w_next = S_WB;
                end else if (r_lw || r_sw) begin
                    w_next = S_MEM;
                end else if (r_sys) begin
                    w_next = S_HALT;
                end else begin
                    w_pc_we = 1'b1;
                    w_next  = S_FETCH;
                    if (r_jr)
                        w_pc_src = 2'd3;
                    else if ((r_beq && ctrl_if.alu_zero) || (r_bne && !ctrl_if.alu_zero))
                        w_pc_src = 2'd1;
                end
            end
            S_MEM: begin
                if (ctrl_if.dmem_ready) begin
                    if (r_lw) begin
                        w_next = S_WB;
                    end else begin
                        w_pc_we = 1'b1;
                        w_next  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_pc_we  = 1'b1;
                w_pc_src = r_jal ? 2'd2 : 2'd0;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                if (ctrl_if.resume) begin
                    w_pc_we = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
            r_aluop   <= '0;
            r_ext_16  <= 1'b0;
            r_ext_s   <= 1'b0;
            r_ext_5   <= 1'b0;
            r_to_wb   <= 1'b0;
            r_lw      <= 1'b0;
            r_sw      <= 1'b0;
            r_jal     <= 1'b0;
            r_beq     <= 1'b0;
            r_bne     <= 1'b0;
            r_jr      <= 1'b0;
            r_sys     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pc_we)
                r_retired <= r_retired + CNT_W'(1);
            if (r_state == S_DECODE) begin
                r_aluop   <= ALUOP_W'(w_aluop);
                r_ext_16  <= w_ext_16;
                r_ext_s   <= w_ext_s;
                r_ext_5   <= w_ext_5;
                r_to_wb   <= w_to_wb;
                r_lw      <= w_lw;
                r_sw      <= w_sw;
                r_jal     <= w_jal;
                r_beq     <= w_beq;
                r_bne     <= w_bne;
                r_jr      <= w_jr;
                r_sys     <= w_sys;
                r_illegal <= w_illegal;
            end
        end
    end

    // No fetch request while reset is held, even though the state sits in FETCH
    assign w_imem_req       = (r_state == S_FETCH) && rst_n;
    assign ctrl_if.imem_req = w_imem_req;
    assign ctrl_if.ir_we    = w_imem_req && ctrl_if.imem_ready;
    assign ctrl_if.dmem_req = (r_state == S_MEM);
    assign ctrl_if.dmem_we  = (r_state == S_MEM) && r_sw;
    assign ctrl_if.aluop    = r_aluop;
    assign ctrl_if.ext_16   = r_ext_16;
    assign ctrl_if.ext_s    = r_ext_s;
    assign ctrl_if.ext_5    = r_ext_5;
    assign ctrl_if.regwrite = (r_state == S_WB);
    assign ctrl_if.jal      = (r_state == S_WB) && r_jal;
    assign ctrl_if.pc_we    = w_pc_we;
    assign ctrl_if.pc_src   = w_pc_src;
    assign ctrl_if.halted   = (r_state == S_HALT);
    assign ctrl_if.illegal  = r_illegal;
    assign ctrl_if.retired  = r_retired;
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter ALUOP_W, default 4, ALU opcode output width; SHALL be >=4, codes zero-extended.
REQ-002 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-003 clk  input  1  single clock; all state SHALL change on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 operator  input  6  instruction bits [31:26] from IR, valid from DECODE onward.
REQ-006 func  input  6  instruction bits [5:0] from IR.
REQ-007 alu_zero  input  1  ALU zero flag, sampled in EXEC.
REQ-008 imem_ready  input  1  instruction memory done; IR loads on the same edge.
REQ-009 dmem_ready  input  1  data memory done.
REQ-010 resume  input  1  leave HALT.
REQ-011 imem_req, ir_we  output  1 each  fetch request; IR load enable.
REQ-012 dmem_req, dmem_we  output  1 each  data access request; write strobe (sw).
REQ-013 aluop  output  ALUOP_W  ALU operation.
REQ-014 ext_16, ext_s, ext_5  output  1 each  zero-extend imm16; sign-extend imm16; shamt select.
REQ-015 regwrite, jal  output  1 each  register-file write strobe; write $31 with PC+4.
REQ-016 pc_we  output  1; pc_src  output  2  PC update; 0=PC+4, 1=branch target, 2=jump target, 3=rs (jr).
REQ-017 halted, illegal  output  1 each  in HALT; last decoded opcode/func unsupported (sticky until next DECODE).
REQ-018 retired  output  CNT_W  count of completed instructions.

Function
REQ-019 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs Moore-decoded from state and latched decode, except ir_we=imem_req&imem_ready.
REQ-020 FETCH: imem_req=1; on imem_ready -> DECODE, else stay.
REQ-021 DECODE: one cycle; decodes operator/func, registers decode flags and illegal; -> EXEC.
REQ-022 Supported: jal 03, beq 04, bne 05, addi 08, addiu 09, slti 0A, andi 0C, ori 0D, lw 23, sw 2B; R-type (op 00) func sll 00, srl 02, sra 03, jr 08, syscall 0C, add 20, addu 21, sub 22, and 24, or 25, nor 27, slt 2A, sltu 2B.
REQ-023 aluop codes: add/addu/addi/addiu/lw/sw 5, sub/beq/bne 6, and/andi 7, or/ori 8, nor A, sll 0, sra 1, srl 2, slt/slti B, sltu C; others 0.
REQ-024 ext_16=andi|ori; ext_s=addi|addiu|slti|lw|sw|beq|bne; ext_5=sll|srl|sra; held from EXEC through WB.
REQ-025 EXEC: ALU/shift/slt ops -> WB; lw/sw -> MEM; jal -> WB; syscall -> HALT; illegal -> retire (NOP); beq/bne/jr -> retire.
REQ-026 Branch retire: pc_src=1 if (beq&alu_zero)|(bne&!alu_zero), else 0; jr pc_src=3.
REQ-027 MEM: dmem_req=1, dmem_we=sw; hold until dmem_ready; lw -> WB, sw -> retire.
REQ-028 WB: regwrite=1 for exactly one cycle; jal=1 and pc_src=2 for jal; retire.
REQ-029 Retire cycle: pc_we=1 for exactly one cycle, retired+=1 (wraps at 2^CNT_W), next state FETCH.
REQ-030 HALT: halted=1, no strobes; on resume: pc_we=1, pc_src=0, retired+=1, -> FETCH. syscall retires only on resume.
REQ-031 regwrite, pc_we, dmem_we, ir_we SHALL never be asserted outside the states above.

Reset
REQ-032 rst_n low SHALL immediately force FETCH, retired=0, illegal=0, all decode flags 0, all strobes 0, aluop=0, pc_src=0; holds mid-fetch or mid-MEM, pending request abandoned.
REQ-033 First imem_req SHALL assert in the first cycle after rst_n deasserts.

Verification
REQ-034 add (op 00, func 20), ready immediate -> FETCH,DECODE,EXEC,WB; aluop=5, regwrite 1 cycle in WB, pc_we with pc_src=0; retired=1.
REQ-035 lw (op 23), dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, ext_s=1, aluop=5, then WB regwrite.
REQ-036 beq with alu_zero=1 -> pc_src=1; bne with alu_zero=1 -> pc_src=0; neither asserts regwrite.
REQ-037 syscall -> halted=1 indefinitely, retired unchanged; resume pulse -> pc_we, retired+1, FETCH.
REQ-038 op 3F -> illegal=1, no regwrite/dmem_req, retired+1; rst_n low during MEM of sw -> dmem_we drops asynchronously, retired=0.
